snake_led_scanner: RTL and testbench
====================================

SNAKE_LED_SCANNER -- requirements
Module: snake_led_scanner

Interface
REQ-001 Clocking and reset are fixed: one clock; reset is asynchronous and active-low (ports named clk and reset).
REQ-002 Parameter ROWS, default 16: number of grid rows scanned.
REQ-003 Parameter COLS, default 16: number of grid columns.
REQ-004 Parameter DWELL_CYCLES, default 1000: clk cycles each row is driven; legal range >=1.
REQ-005 Parameter BLANK_CYCLES, default 8: clk cycles of all-off between rows (anti-ghosting); legal range >=1.
REQ-006 clk  input  1  system clock.
REQ-007 reset  input  1  asynchronous active-low reset.
REQ-008 enable  input  1  level; 1 = scan frames continuously, 0 = stop after the current frame.
REQ-009 red_in  input  ROWS*COLS  per-cell red outputs of the cell array; cell (r,c) at bit r*COLS+c.
REQ-010 green_in  input  ROWS*COLS  per-cell green outputs, same mapping; red+green both 1 = orange.
REQ-011 row_sel  output  ROWS  one-hot active-high row strobe.
REQ-012 col_red  output  COLS  red column drive for the selected row.
REQ-013 col_green  output  COLS  green column drive for the selected row.
REQ-014 row_idx  output  $clog2(ROWS)  index of the row currently being scanned.
REQ-015 frame_done  output  1  one-cycle pulse at the end of each completed frame.

Function
REQ-016 FSM states IDLE, LOAD, DRIVE, BLANK; IDLE: all outputs 0; when enable=1, the FSM moves to LOAD on the next clk edge.
REQ-017 LOAD lasts exactly one cycle: the block captures red_in/green_in into a frame snapshot, sets row_idx=0, and moves to DRIVE.
REQ-018 Input changes after LOAD do not affect outputs until the next LOAD (no tearing).
REQ-019 DRIVE: row_sel has only bit row_idx set; col_red/col_green equal the snapshot row row_idx; state held exactly DWELL_CYCLES cycles, then BLANK.
REQ-020 BLANK: row_sel, col_red, col_green all 0 for exactly BLANK_CYCLES cycles.
REQ-021 End of BLANK with row_idx<ROWS-1: row_idx increments and the FSM moves to DRIVE.
REQ-022 End of BLANK with row_idx==ROWS-1: frame_done=1 for the next single cycle; next state is LOAD if enable=1, else IDLE; row_idx wraps to 0.
REQ-023 Frame period is exactly 1+ROWS*(DWELL_CYCLES+BLANK_CYCLES) cycles, back-to-back, with no idle gap while enable=1.
REQ-024 enable deasserted mid-frame: the current frame completes normally; enable toggling within a frame is ignored except at the REQ-022 decision point.
REQ-025 Outputs are registered; row_sel and column outputs change on the same clk edge, so no cycle shows a row with stale columns.
REQ-026 The dwell/blank counter is a single down-counter sized $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1) and reloads on every state entry.

Reset
REQ-027 While reset=0, the block asynchronously forces state=IDLE, counters=0, row_idx=0, snapshot=0, and all outputs=0.
REQ-028 Deassertion is synchronized so the first FSM transition occurs no earlier than the second clk edge after reset rises.
REQ-029 Reset asserted mid-frame clears outputs immediately (same cycle, before the next edge); no frame_done is emitted.

Structure
REQ-030 Shared package snake_pkg holds the cellStateColor enum (off=00, green=01, red=10, orange=11) and the scan-state enum.
REQ-031 Single module, no sub-modules; snapshot, counter, and FSM are in one file.

Verification (ROWS=4, COLS=4, DWELL_CYCLES=3, BLANK_CYCLES=2; frame=21 cycles)
REQ-032 Reset low with enable=1, then reset high -> all outputs 0 until LOAD; row_sel=0001 appears on the cycle after LOAD.
REQ-033 red_in=16'h000F, green_in=16'hF000 -> row0: col_red=1111 for 3 cycles; row3: col_green=1111; BLANK=0000 for 2 cycles between rows.
REQ-034 Change red_in to 16'hFFFF during row1 DRIVE -> rows 1-3 of the current frame are unchanged; the next frame shows all red.
REQ-035 enable held 1 -> frame_done pulses are exactly 21 cycles apart, each 1 cycle wide; enable dropped at row2 -> frame finishes, then IDLE.
REQ-036 reset pulsed low during row2 DRIVE -> outputs 0 without waiting for a clk edge; no frame_done; restart begins at row0.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg -- shared types for the snake LED scanner.
//   cellStateColor : colour of one bicolour cell, {red, green} bit pair
//   scan_state_e   : scanner FSM states
package snake_pkg;

    typedef enum logic [1:0] {
        off    = 2'b00,
        green  = 2'b01,
        red    = 2'b10,
        orange = 2'b11
    } cellStateColor;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_LOAD  = 2'b01,
        S_DRIVE = 2'b10,
        S_BLANK = 2'b11
    } scan_state_e;

endpackage

// File: rtl/snake_led_scanner.sv
// snake_led_scanner -- row-multiplexed driver for a ROWS x COLS red/green LED grid.
// Each frame: one LOAD cycle that snapshots the cell array, then for every row
// DWELL_CYCLES of drive followed by BLANK_CYCLES of all-off.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   enable          1 = scan frames back to back, 0 = stop after current frame
//   red_in/green_in per-cell colour bits, cell (r,c) at bit r*COLS+c
//   row_sel         one-hot row strobe
//   col_red/green   column drive for the selected row
//   row_idx         row currently being scanned
//   frame_done      one-cycle pulse after the last row's blank
module snake_led_scanner
    import snake_pkg::*;
#(
    parameter int ROWS         = 16,
    parameter int COLS         = 16,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 8,
    localparam int RW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] red_in,
    input  logic [ROWS*COLS-1:0] green_in,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_red,
    output logic [COLS-1:0]      col_green,
    output logic [RW-1:0]        row_idx,
    output logic                 frame_done
);

    localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    scan_state_e          state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [RW-1:0]        row_nxt;
    logic                 done_nxt;
    logic [ROWS*COLS-1:0] snap_red, snap_green;
    logic [ROWS*COLS-1:0] src_red, src_green;
    logic [1:0]           rst_pipe;
    logic                 run;

    // Reset release is re-timed through two flops; the FSM stays frozen
    // until the release has propagated, so it never moves on a marginal edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rst_pipe <= 2'b00;
        else        rst_pipe <= {rst_pipe[0], 1'b1};
    end
    assign run = rst_pipe[1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        row_nxt   = row_idx;
        done_nxt  = 1'b0;
        if (run) begin
            case (state)
                S_IDLE: begin
                    if (enable) state_nxt = S_LOAD;
                end
                S_LOAD: begin
                    state_nxt = S_DRIVE;
                    cnt_nxt   = CW'(DWELL_CYCLES - 1);
                    row_nxt   = '0;
                end
                S_DRIVE: begin
                    if (cnt == '0) begin
                        state_nxt = S_BLANK;
                        cnt_nxt   = CW'(BLANK_CYCLES - 1);
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                S_BLANK: begin
                    if (cnt == '0) begin
                        if (row_idx == RW'(ROWS - 1)) begin
                            // Frame end: enable is only sampled here.
                            done_nxt  = 1'b1;
                            row_nxt   = '0;
                            cnt_nxt   = '0;
                            state_nxt = enable ? S_LOAD : S_IDLE;
                        end else begin
                            row_nxt   = row_idx + 1'b1;
                            state_nxt = S_DRIVE;
                            cnt_nxt   = CW'(DWELL_CYCLES - 1);
                        end
                    end else begin
                        cnt_nxt = cnt - 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // The snapshot is taken on the edge leaving LOAD; row 0 of that same
    // edge is fed straight from the inputs so it matches the snapshot.
    assign src_red   = (state == S_LOAD) ? red_in   : snap_red;
    assign src_green = (state == S_LOAD) ? green_in : snap_green;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            row_idx    <= '0;
            snap_red   <= '0;
            snap_green <= '0;
            row_sel    <= '0;
            col_red    <= '0;
            col_green  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            row_idx    <= row_nxt;
            frame_done <= done_nxt;
            if (state == S_LOAD) begin
                snap_red   <= red_in;
                snap_green <= green_in;
            end
            // Row strobe and columns come from the next state on the same
            // edge, so a row is never shown with stale column data.
            if (state_nxt == S_DRIVE) begin
                row_sel   <= ROWS'(1) << row_nxt;
                col_red   <= src_red[int'(row_nxt) * COLS +: COLS];
                col_green <= src_green[int'(row_nxt) * COLS +: COLS];
            end else begin
                row_sel   <= '0;
                col_red   <= '0;
                col_green <= '0;
            end
        end
    end

endmodule

// File: tb/tb_snake_led_scanner.sv
// Scoreboard bench for snake_led_scanner (4x4 grid, dwell 3, blank 2).
// A frame-position reference model pushes the expected outputs for every
// cycle; a monitor pops and compares them half a cycle later.
module tb_snake_led_scanner;

    localparam int R  = 4;
    localparam int C  = 4;
    localparam int D  = 3;
    localparam int B  = 2;
    localparam int RB = D + B;
    localparam int N  = R * RB;
    localparam int SYNC_EDGES = 2;

    logic          clk;
    logic          reset;
    logic          enable;
    logic [R*C-1:0] red_in, green_in;
    logic [R-1:0]  row_sel;
    logic [C-1:0]  col_red, col_green;
    logic [1:0]    row_idx;
    logic          frame_done;

    typedef struct packed {
        logic [R-1:0] rs;
        logic [C-1:0] cr;
        logic [C-1:0] cg;
        logic [1:0]   ri;
        logic         fd;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;

    snake_led_scanner #(
        .ROWS(R), .COLS(C), .DWELL_CYCLES(D), .BLANK_CYCLES(B)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .red_in(red_in), .green_in(green_in),
        .row_sel(row_sel), .col_red(col_red), .col_green(col_green),
        .row_idx(row_idx), .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: pos = -1 idle, 0 load cycle, 1..N position in frame.
    int             pos = -1;
    int             sync_cnt = 0;
    logic [R*C-1:0] snap_r = '0, snap_g = '0;

    always @(posedge clk) begin
        exp_t e;
        int   p, row, off;
        logic fd;
        cycle++;
        fd = 1'b0;
        if (!reset) begin
            pos = -1; sync_cnt = 0; snap_r = '0; snap_g = '0;
        end else if (sync_cnt < SYNC_EDGES) begin
            sync_cnt++;
        end else if (pos == -1) begin
            if (enable) pos = 0;
        end else if (pos == 0) begin
            snap_r = red_in; snap_g = green_in; pos = 1;
        end else if (pos == N) begin
            fd  = 1'b1;
            pos = enable ? 0 : -1;
        end else begin
            pos++;
        end
        e = '0;
        e.fd = fd;
        if (pos >= 1) begin
            p   = pos - 1;
            row = p / RB;
            off = p % RB;
            e.ri = row[1:0];
            if (off < D) begin
                e.rs = 4'b0001 << row;
                e.cr = snap_r[row*C +: C];
                e.cg = snap_g[row*C +: C];
            end
        end
        expq.push_back(e);
    end

    // Reset forces outputs low at once, so the pending expectation is cleared.
    always @(negedge reset) begin
        if (expq.size() > 0) expq[expq.size()-1] = '0;
    end

    always @(negedge clk) begin
        exp_t e, g;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            g = {row_sel, col_red, col_green, row_idx, frame_done};
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL scan cyc%0d: got rs=%b cr=%b cg=%b ri=%0d fd=%b expected rs=%b cr=%b cg=%b ri=%0d fd=%b",
                         cycle, g.rs, g.cr, g.cg, g.ri, g.fd, e.rs, e.cr, e.cg, e.ri, e.fd);
            end
        end
    end

    task automatic chk_zero(input string name);
        checks++;
        if (row_sel !== '0 || col_red !== '0 || col_green !== '0 ||
            row_idx !== '0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL %s: got rs=%b cr=%b cg=%b ri=%0d fd=%b expected all zero",
                     name, row_sel, col_red, col_green, row_idx, frame_done);
        end
    endtask

    task automatic wait_row2(input string name);
        int guard = 0;
        while (!(row_idx == 2'd2 && row_sel != '0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            errors++;
            $display("FAIL %s: got no row2 drive within 200 cycles, expected one", name);
        end
    endtask

    initial begin
        reset    = 1'b0;
        enable   = 1'b1;
        red_in   = 16'h000F;
        green_in = 16'hF000;
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_hold");
        @(negedge clk) reset = 1'b1;

        // Into row1 drive of the first frame, then flip to all red.
        repeat (10) @(negedge clk);
        red_in = 16'hFFFF;
        repeat (40) @(negedge clk);

        // Random cell data every cycle, occasional enable drops.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            red_in   = 16'($urandom);
            green_in = 16'($urandom);
            enable   = ($urandom_range(0, 7) != 0);
        end

        // Steady scanning, then drop enable during row2 and let it idle.
        enable = 1'b1;
        repeat (50) @(negedge clk);
        wait_row2("enable_drop_wait");
        enable = 1'b0;
        repeat (40) @(negedge clk);
        chk_zero("idle_after_stop");

        // Restart, then pulse reset in the middle of row2 drive.
        enable = 1'b1;
        repeat (5) @(negedge clk);
        wait_row2("reset_pulse_wait");
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_zero("async_reset_clear");
        repeat (2) @(negedge clk);
        chk_zero("reset_low_hold");
        reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            red_in   = 16'($urandom);
            green_in = 16'($urandom);
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
